usb_cdc_stream_adapter: RTL and testbench

- Parametrised byte-stream adapter between the chip-side application pins and the usb_cdc core's bulk IN/OUT byte streams.
- Adds independent IN and OUT buffering, each with a configurable depth.
- Adds run-time selectable modes:
  - normal pass-through;
  - host loopback;
  - on-chip pattern generator, for bring-up without external logic.
- Sits between the pin-adapter top level and the usb_cdc instance, in the single usb/app clock domain.

---
 rtl/usb_cdc_adapter_pkg.sv | 23 ++
 rtl/stream_sync_fifo.sv | 70 +++++++
 rtl/usb_cdc_stream_adapter.sv | 161 ++++++++++++++++
 tb/tb_usb_cdc_stream_adapter.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_cdc_adapter_pkg.sv
// Shared definitions for the usb_cdc stream adapter.
//   mode_e          run-time operating mode of the adapter
//   normalise_mode  maps the raw 2-bit mode pins onto mode_e (11 -> normal)
//   DEFAULT_DATA_W  default stream width (usb_cdc side is byte-wide)
package usb_cdc_adapter_pkg;

    localparam int unsigned DEFAULT_DATA_W = 8;

    typedef enum logic [1:0] {
        MODE_NORMAL   = 2'b00,
        MODE_LOOPBACK = 2'b01,
        MODE_PATTERN  = 2'b10
    } mode_e;

    function automatic mode_e normalise_mode(input logic [1:0] raw);
        case (raw)
            2'b01:   return MODE_LOOPBACK;
            2'b10:   return MODE_PATTERN;
            default: return MODE_NORMAL;
        endcase
    endfunction

endpackage

// File: rtl/stream_sync_fifo.sv
// Register-based first-word-fall-through FIFO with valid/ready ports.
//   clk_i                 clock
//   clr_i                 synchronous clear (empties the FIFO)
//   wr_data_i/valid/ready write port, ready = !full
//   rd_data_o/valid/ready read port, valid = !empty, data held until popped
//   level_o               registered occupancy, 0..DEPTH
// A write into an empty FIFO is visible on the read port one cycle later;
// a pop on a full FIFO frees the slot for writing only on the next cycle.
module stream_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                         clk_i,
    input  logic                         clr_i,
    input  logic [WIDTH-1:0]             wr_data_i,
    input  logic                         wr_valid_i,
    output logic                         wr_ready_o,
    output logic [WIDTH-1:0]             rd_data_o,
    output logic                         rd_valid_o,
    input  logic                         rd_ready_i,
    output logic [$clog2(DEPTH+1)-1:0]   level_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] count;
    logic             do_wr;
    logic             do_rd;

    always_comb begin
        wr_ready_o = (count != LVL_W'(DEPTH));
        rd_valid_o = (count != '0);
        rd_data_o  = mem[rd_ptr];
        level_o    = count;
        do_wr      = wr_valid_i && wr_ready_o;
        do_rd      = rd_valid_o && rd_ready_i;
    end

    always_ff @(posedge clk_i) begin
        if (do_wr && !clr_i) begin
            mem[wr_ptr] <= wr_data_i;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/usb_cdc_stream_adapter.sv
// Byte-stream adapter between the application pins and the usb_cdc bulk
// IN/OUT streams, with an IN FIFO (device->host) and an OUT FIFO
// (host->device) and three run-time modes:
//   normal    app_in -> IN FIFO -> usb_in, usb_out -> OUT FIFO -> app_out
//   loopback  OUT FIFO output feeds the IN FIFO write port
//   pattern   incrementing counter feeds the IN FIFO, OUT FIFO is discarded
// Ports:
//   clk_i, rst_i             clock, synchronous active-high reset
//   mode_i                   00 normal, 01 loopback, 10 pattern, 11 = 00
//   app_in_*                 application bytes toward the host
//   app_out_*                host bytes toward the application
//   usb_in_*                 to usb_cdc bulk IN stream
//   usb_out_*                from usb_cdc bulk OUT stream
//   in_level_o, out_level_o  FIFO occupancies
// A mode change costs one flush cycle: both FIFOs are emptied, every
// valid/ready output is held low, and the pattern counter is reloaded.
module usb_cdc_stream_adapter
    import usb_cdc_adapter_pkg::*;
#(
    parameter int unsigned DATA_W    = DEFAULT_DATA_W,
    parameter int unsigned IN_DEPTH  = 16,
    parameter int unsigned OUT_DEPTH = 16,
    parameter logic [7:0]  PAT_START = 8'h00
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [1:0]                       mode_i,
    input  logic [DATA_W-1:0]                app_in_data_i,
    input  logic                             app_in_valid_i,
    output logic                             app_in_ready_o,
    output logic [DATA_W-1:0]                app_out_data_o,
    output logic                             app_out_valid_o,
    input  logic                             app_out_ready_i,
    output logic [DATA_W-1:0]                usb_in_data_o,
    output logic                             usb_in_valid_o,
    input  logic                             usb_in_ready_i,
    input  logic [DATA_W-1:0]                usb_out_data_i,
    input  logic                             usb_out_valid_i,
    output logic                             usb_out_ready_o,
    output logic [$clog2(IN_DEPTH+1)-1:0]    in_level_o,
    output logic [$clog2(OUT_DEPTH+1)-1:0]   out_level_o
);

    mode_e             mode_q;
    mode_e             mode_n;
    logic              flush;
    logic              active;
    logic              fifo_clr;
    logic [7:0]        pat_cnt;

    logic [DATA_W-1:0] in_wr_data;
    logic              in_wr_valid;
    logic              in_wr_ready;
    logic [DATA_W-1:0] in_rd_data;
    logic              in_rd_valid;
    logic              in_rd_ready;

    logic              out_wr_valid;
    logic              out_wr_ready;
    logic [DATA_W-1:0] out_rd_data;
    logic              out_rd_valid;
    logic              out_rd_ready;

    // Mode state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mode_q <= MODE_NORMAL;
        end else begin
            mode_q <= mode_n;
        end
    end

    // Next mode; any difference from the registered mode is a flush cycle.
    always_comb begin
        mode_n   = normalise_mode(mode_i);
        flush    = !rst_i && (mode_n != mode_q);
        active   = !rst_i && !flush;
        fifo_clr = rst_i || flush;
    end

    // Datapath steering. Outside the active state every handshake is
    // suppressed on both sides, including the FIFOs' internal ports, so a
    // byte presented during reset or flush is never half-accepted.
    always_comb begin
        in_wr_valid     = 1'b0;
        in_wr_data      = '0;
        in_rd_ready     = 1'b0;
        out_wr_valid    = 1'b0;
        out_rd_ready    = 1'b0;
        app_in_ready_o  = 1'b0;
        app_out_valid_o = 1'b0;
        usb_in_valid_o  = 1'b0;
        usb_out_ready_o = 1'b0;
        if (active) begin
            usb_in_valid_o  = in_rd_valid;
            in_rd_ready     = usb_in_ready_i;
            usb_out_ready_o = out_wr_ready;
            out_wr_valid    = usb_out_valid_i;
            case (mode_q)
                MODE_LOOPBACK: begin
                    in_wr_valid  = out_rd_valid;
                    in_wr_data   = out_rd_data;
                    out_rd_ready = in_wr_ready;
                end
                MODE_PATTERN: begin
                    in_wr_valid  = 1'b1;
                    in_wr_data   = DATA_W'(pat_cnt);
                    out_rd_ready = 1'b1;
                end
                default: begin
                    app_in_ready_o  = in_wr_ready;
                    in_wr_valid     = app_in_valid_i;
                    in_wr_data      = app_in_data_i;
                    app_out_valid_o = out_rd_valid;
                    out_rd_ready    = app_out_ready_i;
                end
            endcase
        end
        usb_in_data_o  = usb_in_valid_o  ? in_rd_data  : '0;
        app_out_data_o = app_out_valid_o ? out_rd_data : '0;
    end

    always_ff @(posedge clk_i) begin
        if (fifo_clr) begin
            pat_cnt <= PAT_START;
        end else if (mode_q == MODE_PATTERN && in_wr_valid && in_wr_ready) begin
            pat_cnt <= pat_cnt + 8'd1;
        end
    end

    stream_sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (IN_DEPTH)
    ) u_in_fifo (
        .clk_i      (clk_i),
        .clr_i      (fifo_clr),
        .wr_data_i  (in_wr_data),
        .wr_valid_i (in_wr_valid),
        .wr_ready_o (in_wr_ready),
        .rd_data_o  (in_rd_data),
        .rd_valid_o (in_rd_valid),
        .rd_ready_i (in_rd_ready),
        .level_o    (in_level_o)
    );

    stream_sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (OUT_DEPTH)
    ) u_out_fifo (
        .clk_i      (clk_i),
        .clr_i      (fifo_clr),
        .wr_data_i  (usb_out_data_i),
        .wr_valid_i (out_wr_valid),
        .wr_ready_o (out_wr_ready),
        .rd_data_o  (out_rd_data),
        .rd_valid_o (out_rd_valid),
        .rd_ready_i (out_rd_ready),
        .level_o    (out_level_o)
    );

endmodule

// File: tb/tb_usb_cdc_stream_adapter.sv
// Self-checking bench for usb_cdc_stream_adapter. Accepted input bytes are
// routed by a mode-level model into expected-output queues; a separate
// monitor pops and compares whenever the DUT completes an output transfer.
module tb_usb_cdc_stream_adapter;

    localparam int M_NORMAL = 0;
    localparam int M_LOOP   = 1;
    localparam int M_PAT    = 2;
    localparam logic [7:0] PAT_START = 8'h00;

    logic       clk;
    logic       rst_i;
    logic [1:0] mode_i;
    logic [7:0] app_in_data_i;
    logic       app_in_valid_i;
    logic       app_in_ready_o;
    logic [7:0] app_out_data_o;
    logic       app_out_valid_o;
    logic       app_out_ready_i;
    logic [7:0] usb_in_data_o;
    logic       usb_in_valid_o;
    logic       usb_in_ready_i;
    logic [7:0] usb_out_data_i;
    logic       usb_out_valid_i;
    logic       usb_out_ready_o;
    logic [4:0] in_level_o;
    logic [4:0] out_level_o;

    int         checks   = 0;
    int         failures = 0;
    int         tb_mode  = M_NORMAL;
    int         n_in_pop = 0;
    logic [7:0] exp_in[$];
    logic [7:0] exp_out[$];
    logic [7:0] e_in;
    logic [7:0] e_out;

    usb_cdc_stream_adapter #(
        .DATA_W    (8),
        .IN_DEPTH  (16),
        .OUT_DEPTH (16),
        .PAT_START (PAT_START)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .mode_i          (mode_i),
        .app_in_data_i   (app_in_data_i),
        .app_in_valid_i  (app_in_valid_i),
        .app_in_ready_o  (app_in_ready_o),
        .app_out_data_o  (app_out_data_o),
        .app_out_valid_o (app_out_valid_o),
        .app_out_ready_i (app_out_ready_i),
        .usb_in_data_o   (usb_in_data_o),
        .usb_in_valid_o  (usb_in_valid_o),
        .usb_in_ready_i  (usb_in_ready_i),
        .usb_out_data_i  (usb_out_data_i),
        .usb_out_valid_i (usb_out_valid_i),
        .usb_out_ready_o (usb_out_ready_o),
        .in_level_o      (in_level_o),
        .out_level_o     (out_level_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: where an accepted input byte must reappear, by mode.
    always @(negedge clk) begin
        if (app_in_valid_i && app_in_ready_o) exp_in.push_back(app_in_data_i);
        if (usb_out_valid_i && usb_out_ready_o) begin
            if (tb_mode == M_NORMAL)    exp_out.push_back(usb_out_data_i);
            else if (tb_mode == M_LOOP) exp_in.push_back(usb_out_data_i);
        end
    end

    // Monitor: compare every completed output transfer.
    always @(negedge clk) begin
        if (usb_in_valid_o && usb_in_ready_i) begin
            n_in_pop++;
            if (exp_in.size() == 0) begin
                checks++; failures++;
                $display("FAIL usb_in_unexpected: got %0h expected no byte", usb_in_data_o);
            end else begin
                e_in = exp_in.pop_front();
                chk("usb_in_data", 32'(usb_in_data_o), 32'(e_in));
            end
        end
        if (app_out_valid_o && app_out_ready_i) begin
            if (exp_out.size() == 0) begin
                checks++; failures++;
                $display("FAIL app_out_unexpected: got %0h expected no byte", app_out_data_o);
            end else begin
                e_out = exp_out.pop_front();
                chk("app_out_data", 32'(app_out_data_o), 32'(e_out));
            end
        end
        if (!rst_i && tb_mode != M_NORMAL)
            chk("app_side_idle", 32'({app_in_ready_o, app_out_valid_o}), 32'd0);
    end

    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic send_app(input logic [7:0] d);
        bit acc = 1'b0;
        app_in_valid_i = 1'b1; app_in_data_i = d;
        for (int k = 0; k < 50 && !acc; k++) begin
            @(negedge clk); acc = app_in_ready_o;
            tick();
        end
        app_in_valid_i = 1'b0;
        chk("send_app_accept", 32'(acc), 32'd1);
    endtask

    task automatic send_usb(input logic [7:0] d);
        bit acc = 1'b0;
        usb_out_valid_i = 1'b1; usb_out_data_i = d;
        for (int k = 0; k < 50 && !acc; k++) begin
            @(negedge clk); acc = usb_out_ready_o;
            tick();
        end
        usb_out_valid_i = 1'b0;
        chk("send_usb_accept", 32'(acc), 32'd1);
    endtask

    task automatic run_random(input int unsigned ncyc, input bit allow_app);
        bit acc_a, acc_u;
        for (int unsigned c = 0; c < ncyc; c++) begin
            @(negedge clk);
            acc_a = app_in_valid_i && app_in_ready_o;
            acc_u = usb_out_valid_i && usb_out_ready_o;
            tick();
            if (!app_in_valid_i || acc_a) begin
                app_in_valid_i = allow_app && ($urandom_range(0, 3) != 0);
                app_in_data_i  = 8'($urandom);
            end
            if (!usb_out_valid_i || acc_u) begin
                usb_out_valid_i = ($urandom_range(0, 3) != 0);
                usb_out_data_i  = 8'($urandom);
            end
            usb_in_ready_i  = ($urandom_range(0, 3) != 0);
            app_out_ready_i = ($urandom_range(0, 2) != 0);
        end
    endtask

    // Finish pending input handshakes and wait for all expected output.
    task automatic drain(input string name);
        bit acc_a, acc_u, done;
        usb_in_ready_i = 1'b1; app_out_ready_i = 1'b1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            acc_a = app_in_valid_i && app_in_ready_o;
            acc_u = usb_out_valid_i && usb_out_ready_o;
            done  = !app_in_valid_i && !usb_out_valid_i &&
                    exp_in.size() == 0 && exp_out.size() == 0;
            tick();
            if (acc_a) app_in_valid_i = 1'b0;
            if (acc_u) usb_out_valid_i = 1'b0;
            if (done) break;
        end
        @(negedge clk);
        chk({name, "_in_left"}, 32'(exp_in.size()), 32'd0);
        chk({name, "_out_left"}, 32'(exp_out.size()), 32'd0);
        chk({name, "_levels"}, 32'({in_level_o, out_level_o}), 32'd0);
        tick();
    endtask

    task automatic set_mode(input logic [1:0] m, input int tm);
        mode_i = m; tb_mode = tm;
        exp_in.delete(); exp_out.delete();
    endtask

    initial begin
        rst_i = 1'b1; mode_i = 2'b00;
        app_in_data_i = '0; app_in_valid_i = 1'b0; app_out_ready_i = 1'b0;
        usb_in_ready_i = 1'b0; usb_out_data_i = '0; usb_out_valid_i = 1'b0;
        tick(); tick();
        @(negedge clk);
        chk("reset_hs", 32'({app_in_ready_o, app_out_valid_o, usb_in_valid_o, usb_out_ready_o}), 32'd0);
        chk("reset_data", 32'({app_out_data_o, usb_in_data_o}), 32'd0);
        chk("reset_levels", 32'({in_level_o, out_level_o}), 32'd0);

        // Normal mode directed: A5 toward host, 3C toward application.
        tick();
        rst_i = 1'b0; usb_in_ready_i = 1'b1;
        app_in_valid_i = 1'b1; app_in_data_i = 8'hA5;
        @(negedge clk); chk("first_accept_ready", 32'(app_in_ready_o), 32'd1);
        tick(); app_in_valid_i = 1'b0;
        @(negedge clk);
        chk("a5_latency_valid", 32'(usb_in_valid_o), 32'd1);
        chk("a5_latency_data", 32'(usb_in_data_o), 32'hA5);
        tick();
        app_out_ready_i = 1'b1; usb_out_valid_i = 1'b1; usb_out_data_i = 8'h3C;
        @(negedge clk); chk("usb_out_ready", 32'(usb_out_ready_o), 32'd1);
        tick(); usb_out_valid_i = 1'b0;
        @(negedge clk);
        chk("3c_valid", 32'(app_out_valid_o), 32'd1);
        chk("3c_data", 32'(app_out_data_o), 32'h3C);
        tick();

        run_random(300, 1'b1);
        drain("normal_rand");

        // Full boundary on the IN FIFO.
        begin
            int acc_cnt = 0;
            usb_in_ready_i = 1'b0;
            app_in_valid_i = 1'b1; app_in_data_i = 8'h40;
            for (int k = 0; k < 17; k++) begin
                @(negedge clk); if (app_in_ready_o) acc_cnt++;
                tick(); app_in_data_i = 8'h40 + 8'(acc_cnt);
            end
            chk("full_accepted", 32'(acc_cnt), 32'd16);
            @(negedge clk);
            chk("full_ready_low", 32'(app_in_ready_o), 32'd0);
            chk("full_level", 32'(in_level_o), 32'd16);
            tick(); usb_in_ready_i = 1'b1;
            @(negedge clk); chk("full_pop_same_cycle_ready", 32'(app_in_ready_o), 32'd0);
            tick(); usb_in_ready_i = 1'b0;
            @(negedge clk);
            chk("full_ready_next_cycle", 32'(app_in_ready_o), 32'd1);
            chk("full_level_after_pop", 32'(in_level_o), 32'd15);
            tick(); app_in_valid_i = 1'b0;
            drain("full");
        end

        // Normal -> loopback with 5 bytes buffered and a host byte in flight.
        usb_in_ready_i = 1'b0;
        for (int k = 0; k < 5; k++) send_app(8'($urandom));
        @(negedge clk); chk("buffered_level", 32'(in_level_o), 32'd5);
        tick();
        set_mode(2'b01, M_LOOP);
        usb_in_ready_i = 1'b1; usb_out_valid_i = 1'b1; usb_out_data_i = 8'h01;
        @(negedge clk);
        chk("flush_hs", 32'({app_in_ready_o, app_out_valid_o, usb_in_valid_o, usb_out_ready_o}), 32'd0);
        tick();
        @(negedge clk);
        chk("flush_levels", 32'({in_level_o, out_level_o}), 32'd0);
        chk("post_flush_ready", 32'(usb_out_ready_o), 32'd1);
        tick(); usb_out_valid_i = 1'b0;
        for (int k = 2; k <= 5; k++) send_usb(8'(k));
        drain("loop_directed");
        run_random(200, 1'b0);
        drain("loop_rand");

        // Pattern mode with continuous host drain and host writes.
        set_mode(2'b10, M_PAT);
        for (int k = 0; k < 600; k++) exp_in.push_back(PAT_START + 8'(k));
        n_in_pop = 0;
        usb_in_ready_i = 1'b1; usb_out_valid_i = 1'b1; usb_out_data_i = 8'($urandom);
        @(negedge clk);
        chk("pat_flush_hs", 32'({usb_in_valid_o, usb_out_ready_o}), 32'd0);
        for (int c = 0; c < 300; c++) begin
            tick();
            @(negedge clk);
            chk("pat_out_ready", 32'(usb_out_ready_o), 32'd1);
            #1;
            if (usb_out_ready_o) begin
                usb_out_valid_i = ($urandom_range(0, 1) != 0);
                usb_out_data_i  = 8'($urandom);
            end
        end
        chk("pat_wrap_covered", 32'(n_in_pop >= 257), 32'd1);
        tick();
        set_mode(2'b00, M_NORMAL);
        @(negedge clk); chk("pat_exit_flush", 32'({usb_in_valid_o, usb_out_ready_o}), 32'd0);
        tick();
        drain("pat_exit");

        // Reset mid-stream with 7 bytes queued.
        usb_in_ready_i = 1'b0;
        for (int k = 0; k < 7; k++) send_app(8'($urandom));
        @(negedge clk); chk("pre_reset_level", 32'(in_level_o), 32'd7);
        tick();
        rst_i = 1'b1; exp_in.delete(); exp_out.delete();
        app_in_valid_i = 1'b1; app_in_data_i = 8'h77;
        usb_out_valid_i = 1'b1; usb_out_data_i = 8'h88;
        usb_in_ready_i = 1'b1;
        @(negedge clk);
        chk("midrst_hs", 32'({app_in_ready_o, app_out_valid_o, usb_in_valid_o, usb_out_ready_o}), 32'd0);
        chk("midrst_data", 32'({app_out_data_o, usb_in_data_o}), 32'd0);
        tick();
        @(negedge clk); chk("midrst_levels", 32'({in_level_o, out_level_o}), 32'd0);
        tick();
        rst_i = 1'b0; set_mode(2'b11, M_NORMAL);
        @(negedge clk);
        chk("mode11_as_normal", 32'({app_in_ready_o, usb_out_ready_o}), 32'd3);
        tick(); app_in_valid_i = 1'b0; usb_out_valid_i = 1'b0;
        drain("post_reset");

        // Leaving reset with loopback selected costs one flush cycle first.
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0; set_mode(2'b01, M_LOOP);
        @(negedge clk); chk("rst_to_loop_flush", 32'(usb_out_ready_o), 32'd0);
        tick();
        @(negedge clk); chk("rst_to_loop_ready", 32'(usb_out_ready_o), 32'd1);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
